imem_fetch: RTL and testbench
=============================

IMEM_FETCH -- requirements
Module: imem_fetch

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning instruction words held (power of two, 16..4096).
REQ-002 SHALL have parameter XLEN, default 32, meaning instruction and address width.
REQ-003 SHALL have parameter NOP_WORD, default 32'h00000013, meaning the word returned on error (RV32I addi x0,x0,0).
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk (input, 1 bit, rising-edge clock) and rst_n (input, 1 bit, asynchronous active-low reset).
REQ-005 SHALL have these load-port inputs: ld_valid (1 bit, program word write strobe), ld_addr (XLEN bits, byte address), ld_data (XLEN bits, word to write), ld_done (1 bit, end-of-load pulse).
REQ-006 SHALL have these fetch-request ports: req_valid (input, 1 bit, fetch request), req_addr (input, XLEN bits, byte address), req_ready (output, 1 bit, request accepted this cycle).
REQ-007 SHALL have these fetch-response ports: rsp_valid (output, 1 bit), rsp_instr (output, XLEN bits), rsp_err (output, 1 bit, misaligned or out-of-range), rsp_ready (input, 1 bit, consumer accepts).
REQ-008 SHALL have input flush (1 bit), which discards all pending responses.
REQ-009 SHALL have output running (1 bit), high in state RUN.

Function
REQ-010 SHALL implement FSM states LOAD and RUN; reset enters LOAD.
REQ-011 In LOAD: ld_valid with aligned in-range ld_addr SHALL write ld_data to word ld_addr[log2(DEPTH)+1:2] at the clock edge; a misaligned or out-of-range ld_addr write SHALL be dropped silently.
REQ-012 In LOAD: req_ready SHALL be 0.
REQ-013 In LOAD: ld_done SHALL move the FSM to RUN on the next edge; an ld_valid in the same cycle SHALL still be written.
REQ-014 In RUN: ld_valid and ld_done SHALL be ignored; memory contents SHALL be read-only.
REQ-015 A request SHALL be accepted when req_valid and req_ready are both high.
REQ-016 Read latency SHALL be 1 cycle: a request accepted at edge N SHALL present rsp_valid at N+1.
REQ-017 A 2-entry response FIFO SHALL hold read results; req_ready = running AND FIFO not full AND NOT flush.
REQ-018 rsp_instr, rsp_err and rsp_valid SHALL come from the FIFO head; the head SHALL pop when rsp_valid and rsp_ready are both high.
REQ-019 While rsp_ready is low, rsp_valid and rsp_instr SHALL hold stable.
REQ-020 Push and pop in the same cycle with the FIFO full SHALL be legal: occupancy stays 2 and order is preserved.
REQ-021 When req_addr[1:0] != 0, or req_addr >= DEPTH*4, the response SHALL be rsp_err=1 and rsp_instr=NOP_WORD, with the same latency as a good read.
REQ-022 flush SHALL empty the FIFO at the next edge and cancel the in-flight read; no response SHALL appear for requests accepted before flush.
REQ-023 Back-to-back requests SHALL sustain 1 response per cycle when rsp_ready is held high.
REQ-024 Address arithmetic SHALL ignore req_addr bits above the range check; there SHALL be no wrap-around aliasing.

Reset
REQ-025 While rst_n is low: state=LOAD, FIFO empty, rsp_valid=0, rsp_err=0, rsp_instr=0, req_ready=0, running=0.
REQ-026 Reset SHALL NOT clear the memory array; contents after reset are undefined until loaded.
REQ-027 Reset asserted mid-operation SHALL drop the in-flight read and all queued responses immediately, without waiting for a clock edge.

Structure
REQ-028 A shared package imem_pkg SHALL hold NOP_WORD, the state enum {LOAD, RUN}, and the response struct {instr, err}.
REQ-029 The design SHALL have one sub-module, imem_rsp_fifo: a parametrised 2-entry synchronous FIFO with push/pop/flush and full/empty flags.
REQ-030 The memory array SHALL be a single-port-write, single-port-read synchronous RAM, inferable as block RAM.

Verification
REQ-031 Scenario: load 0x0 to 0x00208133, 0x4 to 0x40110133, then ld_done, then fetch 0x0 and 0x4 back-to-back with rsp_ready=1 -> rsp_valid on consecutive cycles with those words and rsp_err=0.
REQ-032 Scenario: fetch 0x2, then fetch DEPTH*4 -> two responses, each with rsp_err=1 and rsp_instr=0x00000013.
REQ-033 Scenario: rsp_ready=0 while issuing 3 requests -> req_ready drops after 2 accepts and rsp_instr stays stable; raising rsp_ready drains the responses in order.
REQ-034 Scenario: flush in the cycle after an accept with 2 entries queued -> no rsp_valid on the next cycle and req_ready returns high the cycle after.
REQ-035 Scenario: req_valid=1 while in LOAD, then ld_valid to 0x8 during RUN -> no accept in LOAD, and a later fetch of 0x8 returns the pre-RUN contents.
REQ-036 Scenario: rst_n low mid-stream with 2 entries queued -> rsp_valid=0 and running=0 asynchronously, and the FSM is back in LOAD.

Source files
------------

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants, FSM state and response record for imem_fetch
package imem_pkg;

    localparam int unsigned           IMEM_XLEN = 32;
    localparam logic [IMEM_XLEN-1:0]  NOP_WORD  = 32'h00000013;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [IMEM_XLEN-1:0] instr;
        logic                 err;
    } rsp_t;

endpackage

// File: rtl/imem_rsp_fifo.sv
// rtl/imem_rsp_fifo.sv - 2-entry synchronous response FIFO with flush
module imem_rsp_fifo
    import imem_pkg::*;
#(
    parameter int unsigned WIDTH = $bits(rsp_t)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] data_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign do_pop  = pop_i && !empty_o;
    // A pop frees the head slot in the same cycle, so a full FIFO may still accept.
    assign do_push = push_i && (!full_o || pop_i);
    assign dout_o  = data_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) data_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/imem_fetch.sv
// rtl/imem_fetch.sv - loadable instruction memory with 1-cycle fetch and 2-deep response queue
module imem_fetch
    import imem_pkg::*;
#(
    parameter int unsigned     DEPTH    = 256,
    parameter int unsigned     XLEN     = IMEM_XLEN,
    parameter logic [XLEN-1:0] NOP_WORD = imem_pkg::NOP_WORD
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ld_valid,
    input  logic [XLEN-1:0] ld_addr,
    input  logic [XLEN-1:0] ld_data,
    input  logic            ld_done,
    input  logic            req_valid,
    input  logic [XLEN-1:0] req_addr,
    output logic            req_ready,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_instr,
    output logic            rsp_err,
    input  logic            rsp_ready,
    input  logic            flush,
    output logic            running
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_e          state_q;
    state_e          state_d;
    logic [XLEN-1:0] mem [DEPTH];
    logic [XLEN-1:0] rdata_q;
    logic            inflight_q;
    logic            err_q;
    logic            ld_ok;
    logic            ld_we;
    logic            req_bad;
    logic            accept;
    logic            occ_full;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    rsp_t            infl_rsp;
    rsp_t            fifo_dout;
    rsp_t            head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= LOAD;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == LOAD && ld_done) state_d = RUN;
    end

    always_comb begin
        running = (state_q == RUN);
        ld_we   = (state_q == LOAD) && ld_valid && ld_ok;
    end

    // Any set bit above the word index means out of range; nothing aliases back in.
    assign ld_ok   = (ld_addr[1:0] == 2'b00) && ((ld_addr >> (AW + 2)) == '0);
    assign req_bad = (req_addr[1:0] != 2'b00) || ((req_addr >> (AW + 2)) != '0);

    // The in-flight read owns a queue slot so total occupancy never exceeds two.
    assign occ_full  = fifo_full || (!fifo_empty && inflight_q);
    assign req_ready = running && !occ_full && !flush;
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (ld_we)  mem[ld_addr[AW+1:2]] <= ld_data;
        if (accept) rdata_q <= mem[req_addr[AW+1:2]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= accept;
            if (accept) err_q <= req_bad;
        end
    end

    // With the queue empty the read register is the head, giving 1-cycle latency;
    // an unconsumed read is moved into the FIFO so its value stays put.
    always_comb begin
        infl_rsp.instr = err_q ? NOP_WORD : rdata_q;
        infl_rsp.err   = err_q;
        head           = fifo_empty ? infl_rsp : fifo_dout;
        rsp_valid      = !fifo_empty || inflight_q;
        rsp_instr      = rsp_valid ? head.instr : '0;
        rsp_err        = rsp_valid && head.err;
        fifo_pop       = rsp_ready && !fifo_empty;
        fifo_push      = inflight_q && !(fifo_empty && rsp_ready);
    end

    imem_rsp_fifo #(
        .WIDTH ($bits(rsp_t))
    ) u_rsp_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (flush),
        .din_i   (infl_rsp),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_imem_fetch.sv
// tb/tb_imem_fetch.sv - directed scoreboard bench for imem_fetch
module tb_imem_fetch;

    localparam int          DEPTH = 256;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_done;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_instr;
    logic        rsp_err;
    logic        rsp_ready;
    logic        flush;
    logic        running;

    imem_fetch #(
        .DEPTH    (DEPTH),
        .XLEN     (32),
        .NOP_WORD (NOP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_done   (ld_done),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_instr (rsp_instr),
        .rsp_err   (rsp_err),
        .rsp_ready (rsp_ready),
        .flush     (flush),
        .running   (running)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_mem [DEPTH];
    int          vectors     = 0;
    int          miscompares = 0;
    bit          model_run   = 1'b0;
    bit          acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: entered just after a falling edge with inputs already driven.
    task automatic cyc();
        exp_t e;
        #1;
        if (rsp_valid === 1'b1 && rsp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_instr", rsp_instr, e.instr);
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            end
        end
        if (req_valid && req_ready === 1'b1) begin
            if (req_addr[1:0] != 2'b00 || req_addr >= DEPTH * 4)
                sb.push_back('{instr: NOP, err: 1'b1});
            else
                sb.push_back('{instr: exp_mem[req_addr[9:2]], err: 1'b0});
        end
        if (flush) sb.delete();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ld(input logic [31:0] a, input logic [31:0] d, input logic done);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        ld_done  = done;
        if (!model_run && a[1:0] == 2'b00 && a < DEPTH * 4) exp_mem[a[9:2]] = d;
        cyc();
        if (done) model_run = 1'b1;
        ld_valid = 1'b0;
        ld_done  = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 8 && sb.size() != 0; i++) cyc();
        check(tag, sb.size(), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        ld_valid  = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        ld_done   = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        flush     = 1'b0;
        #1;
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_rsp_instr", rsp_instr, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_running", {31'd0, running}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;

        // LOAD phase: requests must be refused, bad loads dropped
        req_valid = 1'b1;
        req_addr  = 32'h0;
        #1;
        check("load_req_ready", {31'd0, req_ready}, 32'd0);
        check("load_running", {31'd0, running}, 32'd0);
        ld(32'h0,   32'h00208133, 1'b0);
        ld(32'h4,   32'h40110133, 1'b0);
        ld(32'h6,   32'hBAD00006, 1'b0);
        ld(32'h400, 32'hBAD00400, 1'b0);
        req_valid = 1'b0;
        ld(32'hC,   32'h00C0000C, 1'b0);
        ld(32'h3FC, 32'h0FF00FF3, 1'b0);
        ld(32'h8,   32'h00800008, 1'b1);
        #1;
        check("run_entered", {31'd0, running}, 32'd1);
        ld(32'h8, 32'hDEADBEEF, 1'b1);

        // back-to-back fetches, one response per cycle
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        cyc();
        req_addr = 32'h4;
        #1;
        check("lat_first", {31'd0, rsp_valid}, 32'd1);
        cyc();
        req_addr = 32'h8;
        #1;
        check("lat_second", {31'd0, rsp_valid}, 32'd1);
        cyc();
        req_valid = 1'b0;
        drain("drain_b2b");

        // misaligned, range boundary and high-bit addresses
        req_valid = 1'b1;
        req_addr  = 32'h2;
        cyc();
        req_addr = 32'h400;
        cyc();
        req_addr = 32'h3FC;
        cyc();
        req_addr = 32'h10000000;
        cyc();
        req_valid = 1'b0;
        drain("drain_err");

        // backpressure: third request waits, head stays stable
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        #1;
        check("bp_ready1", {31'd0, req_ready}, 32'd1);
        cyc();
        req_addr = 32'h4;
        #1;
        check("bp_ready2", {31'd0, req_ready}, 32'd1);
        cyc();
        req_addr = 32'h8;
        #1;
        check("bp_ready_low", {31'd0, req_ready}, 32'd0);
        check("bp_head", rsp_instr, 32'h00208133);
        cyc();
        #1;
        check("bp_stable", rsp_instr, 32'h00208133);
        check("bp_valid_held", {31'd0, rsp_valid}, 32'd1);
        cyc();
        rsp_ready = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 4 && !acc; i++) begin
            #1;
            acc = req_ready;
            cyc();
        end
        check("bp_accept3", {31'd0, acc}, 32'd1);
        req_valid = 1'b0;
        drain("drain_bp");

        // flush with two entries pending
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        cyc();
        req_addr = 32'h4;
        cyc();
        flush    = 1'b1;
        req_addr = 32'h8;
        #1;
        check("flush_ready", {31'd0, req_ready}, 32'd0);
        cyc();
        flush     = 1'b0;
        req_valid = 1'b0;
        #1;
        check("flush_no_valid", {31'd0, rsp_valid}, 32'd0);
        check("flush_ready_back", {31'd0, req_ready}, 32'd1);
        cyc();
        #1;
        check("flush_still_empty", {31'd0, rsp_valid}, 32'd0);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'hC;
        cyc();
        req_valid = 1'b0;
        drain("drain_flush");

        // asynchronous reset with two entries pending
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        cyc();
        req_addr = 32'h4;
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("arst_running", {31'd0, running}, 32'd0);
        check("arst_req_ready", {31'd0, req_ready}, 32'd0);
        sb.delete();
        model_run = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("arst_in_load", {31'd0, running}, 32'd0);
        ld(32'h10, 32'h12345678, 1'b1);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h10;
        cyc();
        req_valid = 1'b0;
        drain("drain_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
